rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
- Read-side master for a 64x20 synchronous-read ROM or block RAM.
- The memory registers its address on the clock edge where its enable is high. Read data is valid in the following cycle and holds while the enable stays low.
- This block issues a burst of sequential addresses, absorbs the 1-cycle read latency, and presents the words on a valid/ready stream with full backpressure support.
- It sits between the microcode/table ROM and a consuming sequencer.

Parameters:
- AW, 6, memory address width; memory depth is 2**AW.
- DW, 20, data word width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- start_addr  in  AW  first address of the burst.
- len  in  AW+1  number of words, 0..64.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at burst completion.
- mem_en  out  1  memory address-register enable.
- mem_addr  out  AW  memory address.
- mem_data  in  DW  memory read data, valid the cycle after mem_en.
- out_valid  out  1  stream word available.
- out_data  out  DW  stream word.
- out_last  out  1  qualifies the final word of a burst.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Interface:
  - One clock. Reset is asynchronous and active-high.
  - Ports are named clk and rst.
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - busy, done, mem_en, mem_addr, out_valid, out_data and out_last all go to 0.
  - FSM goes to IDLE; FIFO and counters are cleared.
  - Words in flight are discarded.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 with len!=0 → RUN. start=1 with len==0 → FIN (no memory access).
  - RUN: an issue counter counts mem_en beats. When the last beat is issued → DRAIN.
  - DRAIN: when the last word (out_last) transfers → FIN.
  - FIN: done=1 for exactly one cycle, busy=0 in that cycle → IDLE.
- start while busy is ignored; it is not queued.
- Issue rule:
  - In RUN, mem_en=1 when issued<len and fifo_count+inflight<4.
  - Both terms are registered. There is no combinational path from out_ready to mem_en.
  - mem_addr starts at start_addr and increments by 1 per issued beat, modulo 2**AW (63 wraps to 0).
  - mem_addr holds its value when mem_en=0.
- Capture:
  - inflight is set in the cycle after mem_en=1.
  - In that cycle, mem_data is pushed into a 4-entry FIFO at the next edge.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head, registered.
  - A transfer occurs when out_valid & out_ready; the head pops.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - out_last=1 only on the len-th word.
- Latency:
  - start sampled at edge N; mem_en=1 with mem_addr=start_addr in cycle N+1.
  - The word is pushed at edge N+2; out_valid=1 in cycle N+3.
  - With out_ready held high, one word transfers per cycle after that.
- Simultaneous push and pop: the count is unchanged and both actions take effect.
- len=64 with start_addr=k reads the full table, from k through k-1.

Optional Feature:
- Macro: ROM_READER_LOOP_EN.
- When defined:
  - An extra input loop (1 bit) is present.
  - In RUN, if loop=1 when the last beat issues, the issue counter and address reload start_addr/len. The FSM stays in RUN.
  - out_last still marks each pass's final word. done is not pulsed while looping.
  - Deasserting loop completes the current pass normally.
- When undefined:
  - The port is absent and every burst is single-pass.

Test Plan:
- Bench memory model: registered address, mem_data = 20'hA0000 | addr.
- start_addr=5, len=4, out_ready=1 → out_data A0005, A0006, A0007, A0008 on consecutive cycles starting N+3. out_last with A0008; done in the following cycle.
- start_addr=62, len=4 → A003E, A003F, A0000, A0001 (address wrap). No extra mem_en beats.
- start_addr=0, len=64, out_ready low for 10 cycles at word 7 → mem_en stops after at most 4 outstanding. All 64 words A0000..A003F arrive exactly once, in order, stable while stalled.
- len=0 → no mem_en, no out_valid, done one cycle after start. A second start during busy of a len=8 burst produces exactly 8 words.
- rst pulsed in cycle N+5 of a len=16 burst → all outputs 0 immediately. A new start_addr=3, len=2 burst then yields A0003, A0004.
- With ROM_READER_LOOP_EN, loop=1 for 3 passes of start_addr=10, len=3 → repeating A000A, A000B, A000C with out_last on each A000C. A single done after loop is dropped.

Source files
------------

// File: rtl/rom_burst_reader.sv
// Burst read master for a synchronous-read ROM: issues sequential addresses, absorbs the
// 1-cycle read latency and streams words out through a 4-entry FIFO. Optional: ROM_READER_LOOP_EN.
module rom_burst_reader #(
  parameter int AW = 6,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
`ifdef ROM_READER_LOOP_EN
  input  logic          loop,
`endif
  output logic          busy,
  output logic          done,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int          FIFO_DEPTH = 4;
  localparam logic [2:0]  CREDITS    = 3'd4;
  localparam logic [AW:0] LEN_ZERO   = '0;
  localparam logic [AW:0] LEN_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mem_en_q, mem_en_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic            mem_last_q, mem_last_d;
  logic            inflight_q;
  logic            inflight_last_q;
`ifdef ROM_READER_LOOP_EN
  logic [AW-1:0]   base_addr_q, base_addr_d;
  logic [AW:0]     base_len_q, base_len_d;
`endif

  logic [DW-1:0]         fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            fifo_count_q;

  logic            fifo_push, fifo_pop, credit_ok, final_xfer;
  logic [2:0]      occupancy;
  logic [AW:0]     eff_rem;
  logic [AW-1:0]   eff_addr;

  // Every word already committed (stored, in the ROM pipeline, or being addressed now)
  // holds a FIFO slot, so a new beat is only issued when one is still free.
  assign occupancy  = fifo_count_q + {2'b00, inflight_q} + {2'b00, mem_en_q};
  assign credit_ok  = (occupancy < CREDITS);
  assign fifo_push  = inflight_q;
  assign fifo_pop   = out_valid & out_ready;
  assign final_xfer = fifo_pop & out_last & (fifo_count_q == 3'd1) & ~inflight_q;

  assign out_valid = (fifo_count_q != 3'd0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    next_addr_d = next_addr_q;
    rem_d       = rem_q;
    mem_last_d  = 1'b0;
    eff_rem     = rem_q;
    eff_addr    = next_addr_q;
`ifdef ROM_READER_LOOP_EN
    base_addr_d = base_addr_q;
    base_len_d  = base_len_q;
    // Once the last beat of a pass is out, looping restarts the address sequence seamlessly.
    if (state_q == RUN && rem_q == LEN_ZERO && loop) begin
      eff_rem  = base_len_q;
      eff_addr = base_addr_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == LEN_ZERO) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d     = RUN;
            busy_d      = 1'b1;
            mem_en_d    = 1'b1;
            mem_addr_d  = start_addr;
            next_addr_d = start_addr + 1'b1;
            rem_d       = len - LEN_ONE;
            mem_last_d  = (len == LEN_ONE);
`ifdef ROM_READER_LOOP_EN
            base_addr_d = start_addr;
            base_len_d  = len;
`endif
          end
        end
      end
      RUN: begin
        if (eff_rem == LEN_ZERO) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          mem_en_d    = 1'b1;
          mem_addr_d  = eff_addr;
          next_addr_d = eff_addr + 1'b1;
          rem_d       = eff_rem - LEN_ONE;
          mem_last_d  = (eff_rem == LEN_ONE);
        end
      end
      DRAIN: begin
        if (final_xfer) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_addr_q      <= '0;
      next_addr_q     <= '0;
      rem_q           <= '0;
      mem_last_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef ROM_READER_LOOP_EN
      base_addr_q     <= '0;
      base_len_q      <= '0;
`endif
      // NOTE: the FIFO storage is reset too; it is only four words and keeps out_data at 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mem_en_q        <= mem_en_d;
      mem_addr_q      <= mem_addr_d;
      next_addr_q     <= next_addr_d;
      rem_q           <= rem_d;
      mem_last_q      <= mem_last_d;
      inflight_q      <= mem_en_q;
      inflight_last_q <= mem_last_q;
`ifdef ROM_READER_LOOP_EN
      base_addr_q     <= base_addr_d;
      base_len_q      <= base_len_d;
`endif
      if (fifo_push) begin
        fifo_data_q[wr_ptr_q] <= mem_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_count_q <= fifo_count_q + 1'b1;
      else if (!fifo_push && fifo_pop) fifo_count_q <= fifo_count_q - 1'b1;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && !fifo_pop && fifo_count_q == CREDITS));

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: ROM model returns 20'hA0000 | addr, and each
// burst is checked against an expected word queue built from start address and length.
module tb_rom_burst_reader;
  localparam int AW = 6;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy, done, mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
`ifdef ROM_READER_LOOP_EN
  logic          loop;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rom_burst_reader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
`ifdef ROM_READER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  // Synchronous-read ROM: address registered on enable, data holds otherwise.
  logic [AW-1:0] rom_addr_q = '0;
  always @(posedge clk) if (mem_en) rom_addr_q <= mem_addr;
  assign mem_data = 20'hA0000 | {{(DW-AW){1'b0}}, rom_addr_q};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 10 cycles at word 7.
  task automatic run_burst(input int sa, input int ln, input int mode, input int passes,
                           input bit extra_start);
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    int issued = 0, xfers = 0, cyc = 0, stall = 0, max_out = 0;
    int first_valid = -1, last_xfer = -1, done_cyc = -1;
    bit stall_used = 0, prev_hold = 0, fin = 0;

    for (int p = 0; p < passes; p++)
      for (int i = 0; i < ln; i++) begin
        exp_d.push_back(20'hA0000 | DW'((sa + i) % 64));
        exp_l.push_back(i == ln - 1);
      end

    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    len        = (AW+1)'(ln);
    out_ready  = 1'b1;
`ifdef ROM_READER_LOOP_EN
    loop = (passes > 1);
`endif

    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = extra_start && cyc == 4;
      if (start) begin
        start_addr = AW'(sa + 17);
        len        = (AW+1)'(3);
      end
      if (cyc == 1) check("busy_after_start", 32'(busy), 32'(ln != 0));

      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (xfers == 7 && !stall_used && stall < 10) begin
             out_ready = 1'b0;
             stall++;
           end else begin
             if (stall == 10) stall_used = 1;
             out_ready = 1'b1;
           end
        default: out_ready = 1'b1;
      endcase

      if (mem_en) begin
        if (ln == 0) check("mem_en_len0", 32'(1), 32'(0));
        else check("mem_addr", 32'(mem_addr), 32'((sa + issued % ln) % 64));
        issued++;
      end
      if (issued - xfers > max_out) max_out = issued - xfers;
`ifdef ROM_READER_LOOP_EN
      if (passes > 1 && issued >= (passes - 1) * ln + 1) loop = 1'b0;
`endif

      if (prev_hold) check("hold_valid", 32'(out_valid), 32'(1));
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_d.size() == 0) begin
          check("extra_word", 32'(out_data), 32'(0));
        end else begin
          check("out_data", 32'(out_data), 32'(exp_d[0]));
          check("out_last", 32'(out_last), 32'(exp_l[0]));
          if (out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            xfers++;
            last_xfer = cyc;
          end
        end
      end
      prev_hold = out_valid && !out_ready;

      if (done) begin
        done_cyc = cyc;
        check("busy_in_done", 32'(busy), 32'(0));
        fin = 1;
      end
    end

    if (!fin) check("timeout_done", 32'(0), 32'(1));
    check("words_left", 32'(exp_d.size()), 32'(0));
    check("issued", 32'(issued), 32'(ln * passes));
    check("credit_le4", 32'(max_out <= 4), 32'(1));
    if (ln == 0) begin
      check("done_len0", 32'(done_cyc), 32'(1));
    end else begin
      check("first_valid_cyc", 32'(first_valid), 32'(3));
      check("done_after_last", 32'(done_cyc), 32'(last_xfer + 1));
      if (mode == 0) check("last_xfer_cyc", 32'(last_xfer), 32'(2 + ln * passes));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_mem_en"}, 32'(mem_en), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(out_data), 32'(0));
    check({tag, "_out_last"}, 32'(out_last), 32'(0));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    out_ready  = 1'b0;
`ifdef ROM_READER_LOOP_EN
    loop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_burst(5, 4, 0, 1, 0);
    run_burst(62, 4, 0, 1, 0);
    run_burst(0, 64, 2, 1, 0);
    run_burst(0, 0, 0, 1, 0);
    run_burst(20, 8, 0, 1, 1);
    run_burst(33, 1, 0, 1, 0);

    // Mid-burst reset.
    @(negedge clk);
    start      = 1'b1;
    start_addr = '0;
    len        = (AW+1)'(16);
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_burst(3, 2, 0, 1, 0);

`ifdef ROM_READER_LOOP_EN
    run_burst(10, 3, 0, 3, 0);
    run_burst(60, 5, 1, 2, 0);
    run_burst(7, 1, 0, 3, 0);
`endif

    for (int n = 0; n < 20; n++) begin
      int sa, ln, mode, passes;
      sa     = $urandom_range(0, 63);
      ln     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 64) : $urandom_range(1, 9);
      mode   = (ln > 8 && $urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, 1);
      passes = 1;
`ifdef ROM_READER_LOOP_EN
      if (ln > 0) passes = $urandom_range(1, 3);
`endif
      run_burst(sa, ln, mode, passes, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
